// File: rtl/dds_waveform_generator_if.sv
// rtl/dds_waveform_generator_if.sv - control strobes, configuration and sample output of the DDS generator
interface dds_waveform_generator_if #(
  parameter int PHASE_W = 24,
  parameter int AMP_W   = 8,
  parameter int DATA_W  = 24
);
  logic               enable;
  logic               phaseReset;
  logic               cfgLoad;
  logic [PHASE_W-1:0] freqWord;
  logic [1:0]         mode;
  logic [AMP_W-1:0]   amplitude;
  logic [DATA_W-1:0]  waveOut;
  logic               waveValid;

  modport master (
    output enable, phaseReset, cfgLoad, freqWord, mode, amplitude,
    input  waveOut, waveValid
  );

  modport slave (
    input  enable, phaseReset, cfgLoad, freqWord, mode, amplitude,
    output waveOut, waveValid
  );
endinterface

// File: rtl/dds_waveform_generator.sv
// rtl/dds_waveform_generator.sv - phase-accumulator waveform source with double-buffered settings
// Sine, square, sawtooth and triangle, two-stage pipeline scaled by an unsigned amplitude.
module dds_waveform_generator #(
  parameter int PHASE_W  = 24,
  parameter int LUT_AW   = 6,
  parameter int SAMPLE_W = 16,
  parameter int AMP_W    = 8,
  parameter int DATA_W   = 24
) (
  input logic                     Clock,
  input logic                     Reset,
  dds_waveform_generator_if.slave bus
);
  localparam int LUT_DEPTH = 1 << LUT_AW;
  localparam int PROD_W    = SAMPLE_W + AMP_W;
  localparam logic signed [SAMPLE_W-1:0] FULL_SCALE = {1'b0, {(SAMPLE_W-1){1'b1}}};

  typedef enum logic [1:0] {
    MODE_SINE   = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_SAW    = 2'd2,
    MODE_TRI    = 2'd3
  } wave_mode_t;

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] activeFreq;
  wave_mode_t         activeMode;
  logic [AMP_W-1:0]   activeAmp;
  logic [PHASE_W-1:0] pendingFreq;
  wave_mode_t         pendingMode;
  logic [AMP_W-1:0]   pendingAmp;
  logic               pendingFlag;

  logic                       launch;
  logic signed [SAMPLE_W-1:0] sample;
  logic [AMP_W-1:0]           sampleAmp;
  logic                       sampleValid;
  logic [DATA_W-1:0]          waveOutReg;
  logic                       waveValidReg;

  logic [PHASE_W:0] phaseSum;
  logic             stepCarry;
  logic             applyNow;

  assign phaseSum  = {1'b0, phase} + {1'b0, activeFreq};
  assign stepCarry = phaseSum[PHASE_W];

  // A stopped generator (freq 0) never wraps, so it takes new settings on any enable.
  always_comb begin
    applyNow = 1'b0;
    if (pendingFlag) begin
      if (bus.phaseReset) begin
        applyNow = 1'b1;
      end else if (bus.enable && (stepCarry || (activeFreq == '0))) begin
        applyNow = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      phase       <= '0;
      activeFreq  <= '0;
      activeMode  <= MODE_SINE;
      activeAmp   <= '0;
      pendingFreq <= '0;
      pendingMode <= MODE_SINE;
      pendingAmp  <= '0;
      pendingFlag <= 1'b0;
    end else begin
      if (bus.phaseReset) begin
        phase <= '0;
      end else if (bus.enable) begin
        phase <= phaseSum[PHASE_W-1:0];
      end

      if (applyNow) begin
        activeFreq <= pendingFreq;
        activeMode <= pendingMode;
        activeAmp  <= pendingAmp;
      end

      // A load racing an apply refills pending after the old contents moved to active.
      if (bus.cfgLoad) begin
        pendingFreq <= bus.freqWord;
        pendingMode <= wave_mode_t'(bus.mode);
        pendingAmp  <= bus.amplitude;
        pendingFlag <= 1'b1;
      end else if (applyNow) begin
        pendingFlag <= 1'b0;
      end
    end
  end

  function automatic logic [SAMPLE_W-1:0] lutEntry(input int i);
    real angle;
    real peak;
    int  v;
    angle = 1.5707963267948966 * (real'(i) + 0.5) / real'(LUT_DEPTH);
    peak  = real'((1 << (SAMPLE_W - 1)) - 1);
    v     = $rtoi(peak * $sin(angle) + 0.5);
    return SAMPLE_W'(v);
  endfunction

  logic [SAMPLE_W-1:0] sineRom [LUT_DEPTH];

  for (genvar gi = 0; gi < LUT_DEPTH; gi++) begin : g_sine_rom
    assign sineRom[gi] = lutEntry(gi);
  end

  logic [SAMPLE_W-1:0] tWord;
  logic [SAMPLE_W-1:0] uWord;
  logic [SAMPLE_W-1:0] triS;
  logic [1:0]          quadrant;
  logic [LUT_AW-1:0]   lutIdx;
  logic [LUT_AW-1:0]   lutAddr;
  logic [SAMPLE_W-1:0] lutVal;

  assign tWord    = phase[PHASE_W-1 -: SAMPLE_W];
  assign uWord    = phase[PHASE_W-2 -: SAMPLE_W];
  assign triS     = {~uWord[SAMPLE_W-1], uWord[SAMPLE_W-2:0]};
  assign quadrant = phase[PHASE_W-1 -: 2];
  assign lutIdx   = phase[PHASE_W-3 -: LUT_AW];
  assign lutAddr  = quadrant[0] ? ~lutIdx : lutIdx;
  assign lutVal   = sineRom[lutAddr];

  logic signed [SAMPLE_W-1:0] waveSample;

  always_comb begin
    waveSample = '0;
    case (activeMode)
      MODE_SINE:   waveSample = quadrant[1] ? -$signed(lutVal) : $signed(lutVal);
      MODE_SQUARE: waveSample = phase[PHASE_W-1] ? -FULL_SCALE : FULL_SCALE;
      MODE_SAW:    waveSample = $signed({~tWord[SAMPLE_W-1], tWord[SAMPLE_W-2:0]});
      MODE_TRI:    waveSample = phase[PHASE_W-1] ? $signed(~triS) : $signed(triS);
      default:     waveSample = '0;
    endcase
  end

  logic signed [PROD_W-1:0] sampleExt;
  logic signed [PROD_W-1:0] ampExt;
  logic signed [PROD_W-1:0] product;

  assign sampleExt = PROD_W'(sample);
  assign ampExt    = PROD_W'(sampleAmp);
  assign product   = sampleExt * ampExt;

  // The amplitude travels with its sample so an apply between stages cannot mix settings.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      launch       <= 1'b0;
      sample       <= '0;
      sampleAmp    <= '0;
      sampleValid  <= 1'b0;
      waveOutReg   <= '0;
      waveValidReg <= 1'b0;
    end else begin
      launch      <= bus.enable && !bus.phaseReset;
      sampleValid <= launch;
      if (launch) begin
        sample    <= waveSample;
        sampleAmp <= activeAmp;
      end
      waveValidReg <= sampleValid;
      if (sampleValid) begin
        waveOutReg <= DATA_W'(product);
      end
    end
  end

  assign bus.waveOut   = waveOutReg;
  assign bus.waveValid = waveValidReg;
endmodule

// File: tb/tb_dds_waveform_generator.sv
// tb/tb_dds_waveform_generator.sv - scoreboard bench for dds_waveform_generator
module tb_dds_waveform_generator;
  localparam int PHASE_W  = 24;
  localparam int LUT_AW   = 6;
  localparam int SAMPLE_W = 16;
  localparam int AMP_W    = 8;
  localparam int DATA_W   = 24;
  localparam longint PMOD = 64'd1 << PHASE_W;
  localparam int LUT_N    = 1 << LUT_AW;
  localparam int HALF     = 1 << (SAMPLE_W - 1);

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  dds_waveform_generator_if #(.PHASE_W(PHASE_W), .AMP_W(AMP_W), .DATA_W(DATA_W)) bus();

  dds_waveform_generator #(
    .PHASE_W(PHASE_W), .LUT_AW(LUT_AW), .SAMPLE_W(SAMPLE_W), .AMP_W(AMP_W), .DATA_W(DATA_W)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus(bus)
  );

  typedef struct {
    int val;
    int due;
  } exp_t;

  int     total = 0;
  int     bad   = 0;
  int     cyc   = 0;
  exp_t   expq[$];
  int     got[$];
  int     lut[LUT_N];

  longint mPhase, mFreq, pFreq;
  int     mMode, pMode, mAmp, pAmp;
  bit     pFlag;

  always @(posedge Clock) cyc <= cyc + 1;

  function automatic void check(string name, longint act, longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endfunction

  function automatic int ref_sample(longint ph, int md);
    longint t, u, q, idx;
    int v;
    t = ph >> (PHASE_W - SAMPLE_W);
    u = (ph >> (PHASE_W - 1 - SAMPLE_W)) % (64'd1 << SAMPLE_W);
    case (md)
      0: begin
        q   = ph >> (PHASE_W - 2);
        idx = (ph >> (PHASE_W - 2 - LUT_AW)) % LUT_N;
        if (q % 2 == 1) idx = LUT_N - 1 - idx;
        v = lut[idx];
        if (q >= 2) v = -v;
      end
      1: v = (ph >= PMOD / 2) ? -(HALF - 1) : (HALF - 1);
      2: v = int'(t) - HALF;
      default: begin
        v = int'(u) - HALF;
        if (ph >= PMOD / 2) v = -1 - v;
      end
    endcase
    return v;
  endfunction

  function automatic int got_at(int i);
    return (i < got.size()) ? got[i] : 32'h7fff_ffff;
  endfunction

  task automatic model_clear();
    mPhase = 0; mFreq = 0; pFreq = 0;
    mMode = 0; pMode = 0; mAmp = 0; pAmp = 0;
    pFlag = 0;
    expq.delete();
  endtask

  task automatic apply_pending();
    mFreq = pFreq; mMode = pMode; mAmp = pAmp; pFlag = 0;
  endtask

  // One clock: drive inputs, let the edge happen, advance the reference and queue any sample launched.
  task automatic drive(input bit en, input bit pr, input bit ld, input longint f, input int md, input int am);
    longint s;
    bit wrap, stopped;
    exp_t e;
    bus.enable     = en;
    bus.phaseReset = pr;
    bus.cfgLoad    = ld;
    bus.freqWord   = PHASE_W'(f);
    bus.mode       = 2'(md);
    bus.amplitude  = AMP_W'(am);
    @(posedge Clock);
    @(negedge Clock);
    if (pr) begin
      mPhase = 0;
      if (pFlag) apply_pending();
    end else if (en) begin
      s       = mPhase + mFreq;
      wrap    = (s >= PMOD);
      stopped = (mFreq == 0);
      mPhase  = s % PMOD;
      if (pFlag && (wrap || stopped)) apply_pending();
    end
    if (ld) begin
      pFreq = f % PMOD; pMode = md; pAmp = am; pFlag = 1;
    end
    if (en && !pr) begin
      e.val = ref_sample(mPhase, mMode) * mAmp;
      e.due = cyc + 2;
      expq.push_back(e);
    end
    check("pending_flag", dut.pendingFlag, pFlag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge Clock) begin
    int act;
    exp_t e;
    if (!Reset && bus.waveValid) begin
      act = int'($signed(bus.waveOut));
      got.push_back(act);
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got sample %0d required no valid", act);
      end else begin
        e = expq.pop_front();
        check("sample_value", act, e.val);
        check("sample_latency", cyc, e.due);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sawExp[8];
    int sqExp[8];
    int asym, peak, a, n0;
    sawExp = '{-24576, -16384, -8192, 0, 8192, 16384, 24576, -32768};
    sqExp  = '{4194176, 4194176, 4194176, 4194176, -4194176, -4194176, -4194176, -4194176};
    for (int i = 0; i < LUT_N; i++)
      lut[i] = $rtoi(real'(HALF - 1) * $sin(3.14159265358979 * (real'(i) + 0.5) / real'(2 * LUT_N)) + 0.5);

    bus.enable = 0; bus.phaseReset = 0; bus.cfgLoad = 0;
    bus.freqWord = '0; bus.mode = '0; bus.amplitude = '0;
    model_clear();
    Reset = 1'b1;
    #12;
    check("reset_waveOut", bus.waveOut, 0);
    check("reset_waveValid", bus.waveValid, 0);
    check("reset_phase", dut.phase, 0);
    @(negedge Clock);
    Reset = 1'b0;

    // Sawtooth, 8 samples per period
    drive(0, 0, 1, 64'd1 << 21, 2, 1);
    drive(0, 1, 0, 0, 0, 0);
    got.delete();
    for (int i = 0; i < 16; i++) drive(1, 0, 0, 0, 0, 0);
    idle(3);
    for (int i = 0; i < 16; i++) check("saw_sequence", got_at(i), sawExp[i % 8]);

    // Switch to a larger step mid-period; takes effect after the wrap
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 64'd1 << 22, 2, 1);
    check("switch_still_old_freq", dut.activeFreq, 64'd1 << 21);
    for (int i = 0; i < 8; i++) drive(1, 0, 0, 0, 0, 0);
    check("switch_new_freq", dut.activeFreq, 64'd1 << 22);

    // Load landing on the wrap edge: older pending applies, newer stays pending
    drive(0, 0, 1, 64'd1 << 20, 3, 2);
    for (int g = 0; g < 64 && (mPhase + mFreq < PMOD); g++) drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 64'd1 << 19, 1, 3);
    check("wrap_load_active", dut.activeFreq, 64'd1 << 20);
    check("wrap_load_pending", dut.pendingFreq, 64'd1 << 19);
    check("wrap_load_flag", dut.pendingFlag, 1);
    for (int i = 0; i < 20; i++) drive(1, 0, 0, 0, 0, 0);
    check("wrap_load_second_apply", dut.activeFreq, 64'd1 << 19);

    // Asynchronous reset while streaming
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0, 0);
    #2 Reset = 1'b1;
    #1;
    check("midreset_waveOut", bus.waveOut, 0);
    check("midreset_waveValid", bus.waveValid, 0);
    model_clear();
    @(negedge Clock);
    Reset = 1'b0;
    check("midreset_phase", dut.phase, 0);
    n0 = got.size();
    idle(3);
    check("no_valid_without_enable", got.size(), n0);

    // Stopped generator picks up a pending load on the next enable
    got.delete();
    drive(0, 0, 1, 64'd1 << 21, 1, 128);
    drive(1, 0, 0, 0, 0, 0);
    check("stopped_apply_freq", dut.activeFreq, 64'd1 << 21);
    for (int i = 0; i < 7; i++) drive(1, 0, 0, 0, 0, 0);
    idle(3);
    for (int i = 0; i < 8; i++) check("square_sequence", got_at(i), sqExp[i]);

    // Sine, 256 samples per period
    drive(0, 0, 1, 64'd1 << 16, 0, 1);
    drive(0, 1, 0, 0, 0, 0);
    idle(3);
    got.delete();
    for (int i = 0; i < 256; i++) drive(1, 0, 0, 0, 0, 0);
    idle(3);
    check("sine_valid_count", got.size(), 256);
    asym = 0;
    peak = 0;
    for (int n = 0; n < 128; n++) if (got_at(n + 128) != -got_at(n)) asym++;
    for (int n = 0; n < got.size() && n < 256; n++) begin
      a = (got[n] < 0) ? -got[n] : got[n];
      if (a > peak) peak = a;
    end
    check("sine_odd_symmetry_errors", asym, 0);
    check("sine_peak", peak, lut[LUT_N-1]);

    // Randomised traffic against the reference
    for (int i = 0; i < 400; i++) begin
      bit en, pr, ld;
      longint f;
      int sel;
      en  = ($urandom_range(0, 3) != 0);
      pr  = ($urandom_range(0, 15) == 0);
      ld  = ($urandom_range(0, 7) == 0);
      sel = $urandom_range(0, 3);
      if (sel == 0)      f = 0;
      else if (sel == 1) f = longint'($urandom_range(1, 4096)) << 10;
      else               f = longint'($urandom) % PMOD;
      drive(en, pr, ld, f, $urandom_range(0, 3), $urandom_range(0, 255));
    end
    idle(4);
    check("scoreboard_drained", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
